// File: rtl/exe_mem_fwd_stage.sv
// MIPS execute stage: operand forwarding, ALU and the EXE/MEM pipeline register.
// Define EXE_FORWARDING_EN to enable MEM/WB operand forwarding; otherwise operands come straight from ID/EXE.
module exe_mem_fwd_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_reg_data1,
    input  logic [DATA_W-1:0] id_reg_data2,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [4:0]        id_shamt,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_alu_src1,
    input  logic [1:0]        id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_data_c,
    input  logic [DATA_W-1:0] id_pc_plus4,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [4:0]        mem_write_reg,
    output logic              mem_reg_write,
    output logic              mem_mem_read,
    output logic              mem_mem_write,
    output logic              mem_mem_to_reg,
    output logic              mem_data_c,
    output logic [DATA_W-1:0] mem_pc_plus4,
    output logic              exe_zero,
    output logic              exe_overflow,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_LUI  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    logic [4:0]               dest_reg;
    logic [DATA_W-1:0]        fwd_a_data;
    logic [DATA_W-1:0]        fwd_b_data;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic [DATA_W-1:0]        alu_result;

    function automatic logic [DATA_W-1:0] alu_calc(
        input logic [3:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [4:0] sh;
        sh = a[4:0];
        case (op)
            OP_AND:  alu_calc = a & b;
            OP_OR:   alu_calc = a | b;
            OP_ADD:  alu_calc = a + b;
            OP_XOR:  alu_calc = a ^ b;
            OP_SLL:  alu_calc = b << sh;
            OP_SRL:  alu_calc = $unsigned(b) >> sh;
            OP_SUB:  alu_calc = a - b;
            OP_SLT:  alu_calc = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SRA:  alu_calc = b >>> sh;
            OP_SLTU: alu_calc = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            OP_LUI:  alu_calc = b << 16;
            OP_NOR:  alu_calc = ~(a | b);
            default: alu_calc = '0;
        endcase
    endfunction

    // Signed overflow: operands effectively share a sign and the result sign differs.
    function automatic logic ovf_calc(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] r
    );
        case (op)
            OP_ADD:  ovf_calc = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            OP_SUB:  ovf_calc = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            default: ovf_calc = 1'b0;
        endcase
    endfunction

    always_comb begin
        case (id_reg_dst)
            2'b01:   dest_reg = id_rd;
            2'b10:   dest_reg = 5'd31;
            default: dest_reg = id_rt;
        endcase
    end

`ifdef EXE_FORWARDING_EN
    // MEM is checked first so the younger result wins; register 0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_reg_write && (mem_write_reg != 5'd0) && (mem_write_reg == src))
            fwd_sel = FWD_MEM;
        else if (wb_reg_write && (wb_write_reg != 5'd0) && (wb_write_reg == src))
            fwd_sel = FWD_WB;
        else
            fwd_sel = FWD_NONE;
    endfunction

    assign forward_a = fwd_sel(id_rs);
    assign forward_b = fwd_sel(id_rt);

    always_comb begin
        case (forward_a)
            FWD_MEM: fwd_a_data = mem_alu_result;
            FWD_WB:  fwd_a_data = wb_result;
            default: fwd_a_data = id_reg_data1;
        endcase
        case (forward_b)
            FWD_MEM: fwd_b_data = mem_alu_result;
            FWD_WB:  fwd_b_data = wb_result;
            default: fwd_b_data = id_reg_data2;
        endcase
    end
`else
    logic unused_wb;

    assign forward_a  = FWD_NONE;
    assign forward_b  = FWD_NONE;
    assign fwd_a_data = id_reg_data1;
    assign fwd_b_data = id_reg_data2;
    assign unused_wb  = ^{wb_reg_write, wb_write_reg, wb_result, id_rs};
`endif

    assign op_a = id_alu_src1 ? {{(DATA_W-5){1'b0}}, id_shamt} : fwd_a_data;
    assign op_b = id_alu_src  ? id_imm_ext : fwd_b_data;

    assign alu_result   = alu_calc(id_alu_op, op_a, op_b);
    assign exe_zero     = (alu_result == '0);
    assign exe_overflow = ovf_calc(id_alu_op, op_a, op_b, alu_result);

    // EXE/MEM boundary: store data is the forwarded rt value regardless of operand B select.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_alu_result <= '0;
            mem_write_data <= '0;
            mem_write_reg  <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            mem_data_c     <= 1'b0;
            mem_pc_plus4   <= '0;
        end else begin
            mem_alu_result <= alu_result;
            mem_write_data <= fwd_b_data;
            mem_write_reg  <= dest_reg;
            mem_reg_write  <= id_reg_write;
            mem_mem_read   <= id_mem_read;
            mem_mem_write  <= id_mem_write;
            mem_mem_to_reg <= id_mem_to_reg;
            mem_data_c     <= id_data_c;
            mem_pc_plus4   <= id_pc_plus4;
        end
    end

endmodule

// File: tb/tb_exe_mem_fwd_stage.sv
// Directed-vector bench for exe_mem_fwd_stage; expectations follow EXE_FORWARDING_EN when defined.
module tb_exe_mem_fwd_stage;

`ifdef EXE_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [31:0] id_reg_data1, id_reg_data2, id_imm_ext, id_pc_plus4;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_alu_src1;
    logic [1:0]  id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_data_c;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_result;
    logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus4;
    logic [4:0]  mem_write_reg;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_data_c;
    logic        exe_zero, exe_overflow;
    logic [1:0]  forward_a, forward_b;

    int n_checks = 0;
    int n_pass   = 0;

    exe_mem_fwd_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_data1(id_reg_data1), .id_reg_data2(id_reg_data2),
        .id_imm_ext(id_imm_ext), .id_shamt(id_shamt), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_alu_src1(id_alu_src1), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_mem_to_reg(id_mem_to_reg), .id_data_c(id_data_c), .id_pc_plus4(id_pc_plus4),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_result(wb_result),
        .mem_alu_result(mem_alu_result), .mem_write_data(mem_write_data),
        .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_data_c(mem_data_c),
        .mem_pc_plus4(mem_pc_plus4), .exe_zero(exe_zero), .exe_overflow(exe_overflow),
        .forward_a(forward_a), .forward_b(forward_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; id_shamt = 5'd0;
        id_reg_data1 = 32'h0; id_reg_data2 = 32'h0; id_imm_ext = 32'h0; id_pc_plus4 = 32'h0;
        id_alu_op = 4'h0; id_alu_src = 1'b0; id_alu_src1 = 1'b0; id_reg_dst = 2'b00;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
        id_mem_to_reg = 1'b0; id_data_c = 1'b0;
        wb_reg_write = 1'b0; wb_write_reg = 5'd0; wb_result = 32'h0;
    endtask

    // Non-forwarding ALU vector: rs/rt point at registers nobody is writing.
    task automatic alu_vec(input string tag, input logic [3:0] op,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic src, input logic [31:0] imm,
                           input logic src1, input logic [4:0] shamt,
                           input logic [31:0] exp_res, input logic exp_zero, input logic exp_ovf);
        clear_inputs();
        id_rs = 5'd20; id_rt = 5'd21;
        id_alu_op = op; id_reg_data1 = d1; id_reg_data2 = d2;
        id_alu_src = src; id_imm_ext = imm; id_alu_src1 = src1; id_shamt = shamt;
        #4;
        check({tag, "_zero"}, {31'b0, exe_zero}, {31'b0, exp_zero});
        check({tag, "_ovf"},  {31'b0, exe_overflow}, {31'b0, exp_ovf});
        step();
        check({tag, "_res"}, mem_alu_result, exp_res);
    endtask

    initial begin
        // Reset with busy inputs
        clear_inputs();
        rst = 1'b1;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_reg_data1 = 32'h1234; id_reg_data2 = 32'h55;
        id_alu_op = 4'b0010; id_reg_dst = 2'b01; id_reg_write = 1'b1; id_mem_read = 1'b1;
        id_mem_write = 1'b1; id_mem_to_reg = 1'b1; id_data_c = 1'b1; id_pc_plus4 = 32'h404;
        step();
        check("rst_alu", mem_alu_result, 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        check("rst_wreg", {27'b0, mem_write_reg}, 32'h0);
        check("rst_ctrl", {27'b0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_data_c}, 32'h0);
        check("rst_pc", mem_pc_plus4, 32'h0);
        rst = 1'b0;

        // ADD without forwarding, dest rd=3
        clear_inputs();
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_reg_data1 = 32'd5; id_reg_data2 = 32'd7;
        id_alu_op = 4'b0010; id_reg_dst = 2'b01; id_reg_write = 1'b1; id_pc_plus4 = 32'h104;
        #4;
        check("add_zero", {31'b0, exe_zero}, 32'h0);
        check("add_fa", {30'b0, forward_a}, 32'h0);
        step();
        check("add_res", mem_alu_result, 32'd12);
        check("add_wreg", {27'b0, mem_write_reg}, 32'd3);
        check("add_regw", {31'b0, mem_reg_write}, 32'h1);
        check("add_wdata", mem_write_data, 32'd7);
        check("add_pc", mem_pc_plus4, 32'h104);

        // MEM (r3=12) and WB (r3=99) both match rs
        clear_inputs();
        id_rs = 5'd3; id_rt = 5'd5; id_rd = 5'd6; id_reg_data1 = 32'd0; id_reg_data2 = 32'd1;
        id_alu_op = 4'b0010; id_reg_dst = 2'b01; id_reg_write = 1'b1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_result = 32'd99;
        #4;
        check("prio_fa", {30'b0, forward_a}, FWD ? 32'h2 : 32'h0);
        check("prio_fb", {30'b0, forward_b}, 32'h0);
        step();
        check("prio_res", mem_alu_result, FWD ? 32'd13 : 32'd1);

        // WB forwards to rt; store data takes it even with immediate operand B
        clear_inputs();
        id_rs = 5'd1; id_rt = 5'd4; id_reg_data1 = 32'h100; id_reg_data2 = 32'h55;
        id_alu_src = 1'b1; id_imm_ext = 32'd8; id_alu_op = 4'b0010; id_mem_write = 1'b1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd4; wb_result = 32'hAB;
        #4;
        check("st_fb", {30'b0, forward_b}, FWD ? 32'h1 : 32'h0);
        check("st_fa", {30'b0, forward_a}, 32'h0);
        step();
        check("st_wdata", mem_write_data, FWD ? 32'hAB : 32'h55);
        check("st_res", mem_alu_result, 32'h108);
        check("st_memw", {31'b0, mem_mem_write}, 32'h1);
        check("st_wreg", {27'b0, mem_write_reg}, 32'd4);

        // Put a write to r0 into MEM, with WB also targeting r0
        clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_reg_data1 = 32'h11; id_reg_data2 = 32'h22;
        id_alu_op = 4'b0010; id_reg_dst = 2'b00; id_reg_write = 1'b1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd0; wb_result = 32'hDEAD;
        step();
        check("r0_wreg", {27'b0, mem_write_reg}, 32'd0);
        check("r0_wdata", mem_write_data, 32'h22);
        id_reg_data1 = 32'd3; id_reg_data2 = 32'd4; id_reg_write = 1'b0;
        #4;
        check("r0_fa", {30'b0, forward_a}, 32'h0);
        check("r0_fb", {30'b0, forward_b}, 32'h0);
        step();
        check("r0_res", mem_alu_result, 32'd7);

        // Destination select and control pipelining
        clear_inputs();
        id_rt = 5'd9; id_rd = 5'd10; id_reg_dst = 2'b10; id_mem_read = 1'b1;
        id_mem_to_reg = 1'b1; id_data_c = 1'b1; id_pc_plus4 = 32'h400;
        step();
        check("dst31", {27'b0, mem_write_reg}, 32'd31);
        check("ctrl", {27'b0, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_data_c}, 32'h0B);
        check("ctrl_pc", mem_pc_plus4, 32'h400);
        id_reg_dst = 2'b11;
        step();
        check("dst11", {27'b0, mem_write_reg}, 32'd9);

        // ALU operations and flags
        alu_vec("add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h80000000, 1'b0, 1'b1);
        alu_vec("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        alu_vec("sub_zero", 4'b0110, 32'd5, 32'd5, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        alu_vec("sub_ovf",  4'b0110, 32'h80000000, 32'h1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1);
        alu_vec("sll",      4'b0100, 32'hFF, 32'h1, 1'b0, 32'h0, 1'b1, 5'd4, 32'd16, 1'b0, 1'b0);
        alu_vec("srl",      4'b0101, 32'h0, 32'hF0000000, 1'b0, 32'h0, 1'b1, 5'd4, 32'h0F000000, 1'b0, 1'b0);
        alu_vec("sra",      4'b1000, 32'h0, 32'hF0000000, 1'b0, 32'h0, 1'b1, 5'd4, 32'hFF000000, 1'b0, 1'b0);
        alu_vec("slt",      4'b0111, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h1, 1'b0, 1'b0);
        alu_vec("sltu",     4'b1001, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        alu_vec("lui",      4'b1010, 32'h0, 32'h0, 1'b1, 32'h1234, 1'b0, 5'd0, 32'h12340000, 1'b0, 1'b0);
        alu_vec("nor",      4'b1100, 32'h0F0F0000, 32'h0000F0F0, 1'b0, 32'h0, 1'b0, 5'd0, 32'hF0F00F0F, 1'b0, 1'b0);
        alu_vec("and",      4'b0000, 32'hF0F0, 32'hFF00, 1'b0, 32'h0, 1'b0, 5'd0, 32'hF000, 1'b0, 1'b0);
        alu_vec("or",       4'b0001, 32'hF0F0, 32'hFF00, 1'b0, 32'h0, 1'b0, 5'd0, 32'hFFF0, 1'b0, 1'b0);
        alu_vec("xor",      4'b0011, 32'hF0F0, 32'hFF00, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0FF0, 1'b0, 1'b0);
        alu_vec("undef",    4'b1011, 32'd5, 32'd7, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
